writeback_stage: RTL and testbench
==================================

# writeback_stage

Final stage of the five-stage RISC-V pipeline and the sole writer of the register file. Captures MEM-stage results into the MEM/WB pipeline register, aligns and extends load data, selects the write-back source, and drives the register file write port. Also provides write-before-read bypass for the register file read ports, so decode sees a value retiring in the same cycle, and maintains the 64-bit retired-instruction counter.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- INSTRET_W, 64: retired-instruction counter width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_reg_write  in  1  instruction writes rd.
- mem_rd_addr  in  5  destination register.
- mem_wb_sel  in  2  source select: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU).
- mem_funct3  in  3  load size/sign code.
- mem_alu_result  in  32  ALU result; for loads, the effective address.
- mem_load_data  in  32  raw aligned 32-bit word from data memory.
- mem_pc_plus4  in  32  link value for jal/jalr.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  replace the captured entry with a bubble.
- rs1_addr, rs2_addr  in  5  decode-stage read addresses.
- rs1_raw, rs2_raw  in  32  register file read data.
- rs1_data, rs2_data  out  32  bypassed read data to decode.
- rd_addr  out  5  register file write address.
- rd_data  out  32  register file write data.
- reg_write  out  1  register file write enable.
- instret  out  64  retired-instruction count.

## Operation
- MEM/WB register priority on each edge: flush, then stall, then normal load.
  - flush: clear wb_valid (bubble).
  - stall: hold all fields.
  - otherwise: load all mem_* fields.
- Load alignment uses funct3 and off = alu_result[1:0] from the registered entry.
  - 000 lb: byte at off, sign-extended.
  - 100 lbu: byte at off, zero-extended.
  - 001 lh: halfword at off[1], sign-extended.
  - 101 lhu: halfword at off[1], zero-extended.
  - 010 lw: full word; offset ignored.
  - 011, 110, 111: raw word passed through.
  - Byte lanes are little-endian: byte k = data[8k+7:8k].
- rd_data is the selected source per wb_sel.
- reg_write = wb_valid & wb_reg_write & (rd_addr != 0) & !written.
  - written sets after the first write cycle of an entry held by stall and clears when a new entry loads.
  - A stalled entry writes exactly once.
- Bypass (combinational): rsX_data = rd_data when reg_write and rsX_addr == rd_addr and rsX_addr != 0; otherwise rsX_raw. x0 always reads rsX_raw.
- instret increments by 1 on every cycle where wb_valid & !written, regardless of reg_write (stores and branches retire too). It wraps modulo 2^64.

## Timing
- Latency: mem_* sampled at edge N drives rd_*/reg_write during cycle N+1. The register file captures at edge N+1.
- Bypass path adds no cycles.
- Reset (rst low, asynchronous) clears wb_valid, all fields, written, and instret.
  - Outputs during reset: reg_write 0, rd_addr 0, rd_data 0, instret 0.
  - rs1_data/rs2_data equal rs1_raw/rs2_raw.
- Reset asserted mid-stall drops the pending entry; it is never written or counted.
- flush and stall asserted together: flush wins.
- Flush removes only the entry that would be captured at that edge. The entry currently in WB has already retired.

## Structure
- Shared riscv_pkg holds:
  - wb_sel encodings WB_ALU, WB_LOAD, WB_PC4.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN.
- One combinational sub-module load_align with inputs (raw word, funct3, offset) and output (32-bit extended value), reused later by the cache refill path.
- The pipeline register, written flag, instret counter, and bypass muxes stay in writeback_stage.

## Test plan
- Reset, then apply: mem_valid=1, reg_write=1, rd=5, wb_sel=ALU, alu=0x1234 -> next cycle: reg_write=1, rd_addr=5, rd_data=0x00001234, instret=1 after that edge.
- Load, load_data=0x80FF7F01, alu low bits=1:
  - lb -> 0x0000007F.
  - lbu at off 2 -> 0x000000FF.
  - lh at off 2 -> 0xFFFF80FF.
  - lhu at off 0 -> 0x00007F01.
- rd=0 with reg_write=1 -> reg_write stays 0, instret still increments. rs1_addr=0 -> rs1_data=rs1_raw.
- Retiring rd=7, data 0xDEAD, with rs2_addr=7 and rs2_raw=0x1111 -> rs2_data=0xDEAD in that same cycle.
- Stall for 3 cycles on a valid rd=3 entry -> reg_write high for one cycle only, instret +1 total. Flush and stall together -> next cycle is a bubble.
- Assert rst low mid-stall -> reg_write drops immediately, instret=0, and after release no write occurs for the dropped entry.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the five-stage RISC-V pipeline.
//   XLEN        : datapath width (only 32 supported)
//   wb_sel_e    : write-back source select encodings
//   F3_*        : load funct3 size/sign codes
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    // Write-back source select; WB_RSVD is decoded as the ALU result.
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load data aligner/extender. Picks the addressed byte or
// halfword out of a little-endian 32-bit memory word and sign- or
// zero-extends it according to the load funct3. Shared with the cache
// refill path, so it carries no pipeline state.
// Ports:
//   raw    : aligned 32-bit word from data memory
//   funct3 : load size/sign code
//   offset : low two address bits of the effective address
//   value  : extended result
// ---------------------------------------------------------------------------
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection (byte k lives in raw[8k+7:8k]), then extension by funct3.
    // Unlisted funct3 codes pass the raw word through unchanged.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase

        half_sel = offset[1] ? raw[31:16] : raw[15:0];

        value = raw;
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  value = {16'd0, half_sel};
            F3_LW:   value = raw;
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage and sole writer of the register file. Holds the
// MEM/WB pipeline register, aligns load data, selects the write-back value,
// bypasses the retiring value onto the decode read ports, and counts retired
// instructions.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   mem_*                    : MEM-stage results captured into MEM/WB
//   stall, flush             : hold / bubble control for MEM/WB
//   rs1_addr/rs2_addr        : decode read addresses
//   rs1_raw/rs2_raw          : register file read data
//   rs1_data/rs2_data        : bypassed read data to decode
//   rd_addr/rd_data/reg_write: register file write port
//   instret                  : retired-instruction counter
// ---------------------------------------------------------------------------
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_rd_addr,
    input  logic [1:0]           mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_load_data,
    input  logic [XLEN-1:0]      mem_pc_plus4,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    input  logic [XLEN-1:0]      rs1_raw,
    input  logic [XLEN-1:0]      rs2_raw,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic [4:0]           rd_addr,
    output logic [XLEN-1:0]      rd_data,
    output logic                 reg_write,
    output logic [INSTRET_W-1:0] instret
);

    logic            wb_valid;
    logic            wb_reg_write;
    logic [4:0]      wb_rd_addr;
    wb_sel_e         wb_sel;
    logic [2:0]      wb_funct3;
    logic [XLEN-1:0] wb_alu_result;
    logic [XLEN-1:0] wb_load_data;
    logic [XLEN-1:0] wb_pc_plus4;
    logic            written;
    logic [XLEN-1:0] load_value;

    // MEM/WB register. Flush beats stall. While stalled, 'written' records
    // that the held entry has already had its one write/retire cycle, so it
    // is neither rewritten nor recounted; a fresh load clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd_addr    <= 5'd0;
            wb_sel        <= WB_ALU;
            wb_funct3     <= 3'd0;
            wb_alu_result <= '0;
            wb_load_data  <= '0;
            wb_pc_plus4   <= '0;
            written       <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            written  <= 1'b0;
        end else if (stall) begin
            written <= written | wb_valid;
        end else begin
            wb_valid      <= mem_valid;
            wb_reg_write  <= mem_reg_write;
            wb_rd_addr    <= mem_rd_addr;
            wb_sel        <= wb_sel_e'(mem_wb_sel);
            wb_funct3     <= mem_funct3;
            wb_alu_result <= mem_alu_result;
            wb_load_data  <= mem_load_data;
            wb_pc_plus4   <= mem_pc_plus4;
            written       <= 1'b0;
        end
    end

    // Every entry retires once, whether or not it writes a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
        end else if (wb_valid && !written) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

    load_align u_load_align (
        .raw    (wb_load_data),
        .funct3 (wb_funct3),
        .offset (wb_alu_result[1:0]),
        .value  (load_value)
    );

    // Write-back source select and register file write port.
    always_comb begin
        case (wb_sel)
            WB_LOAD: rd_data = load_value;
            WB_PC4:  rd_data = wb_pc_plus4;
            default: rd_data = wb_alu_result;
        endcase
        rd_addr   = wb_rd_addr;
        reg_write = wb_valid & wb_reg_write & (wb_rd_addr != 5'd0) & ~written;
    end

    // Write-before-read bypass; reg_write already excludes x0.
    always_comb begin
        rs1_data = rs1_raw;
        rs2_data = rs2_raw;
        if (reg_write && (rs1_addr == rd_addr) && (rs1_addr != 5'd0)) begin
            rs1_data = rd_data;
        end
        if (reg_write && (rs2_addr == rd_addr) && (rs2_addr != 5'd0)) begin
            rs2_data = rd_data;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
// Scoreboard bench for writeback_stage: each driven MEM-stage entry pushes
// its expected write-port values; they are popped and compared one cycle
// later when the entry sits in WB. instret is tracked by a small model.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc_plus4;
    logic        stall;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_raw;
    logic [31:0] rs2_raw;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write;
    logic [63:0] instret;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        last_exp;
    logic [63:0] exp_instret;
    logic        model_live;
    int          n_checks;
    int          n_fail;

    writeback_stage #(.XLEN(32), .INSTRET_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd_addr    (mem_rd_addr),
        .mem_wb_sel     (mem_wb_sel),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .mem_pc_plus4   (mem_pc_plus4),
        .stall          (stall),
        .flush          (flush),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_raw        (rs1_raw),
        .rs2_raw        (rs2_raw),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .reg_write      (reg_write),
        .instret        (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference load extraction: shift the word down to the addressed lane.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3,
                                              input logic [31:0] w,
                                              input logic [1:0] off);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> (8 * off);
        sh = w >> (16 * off[1]);
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'd0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] modelBypass(input logic [4:0] a,
                                                input logic [31:0] raw,
                                                input exp_t e);
        if (e.rw && a == e.rd && a != 5'd0) return e.data;
        return raw;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (model_live) exp_instret++;
    endtask

    task automatic applyStimulus(input logic v, input logic rw,
                                 input logic [4:0] rd, input logic [1:0] sel,
                                 input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] ld, input logic [31:0] pc4);
        exp_t e;
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_rd_addr    = rd;
        mem_wb_sel     = sel;
        mem_funct3     = f3;
        mem_alu_result = alu;
        mem_load_data  = ld;
        mem_pc_plus4   = pc4;
        stall          = 1'b0;
        flush          = 1'b0;
        e.rw   = v && rw && (rd != 5'd0);
        e.rd   = rd;
        e.data = (sel == 2'd1) ? modelLoad(f3, ld, alu[1:0]) :
                 (sel == 2'd2) ? pc4 : alu;
        sbq.push_back(e);
        tick();
        model_live = v;
        last_exp = sbq.pop_front();
        checkOutput("reg_write", {63'd0, reg_write}, {63'd0, last_exp.rw});
        checkOutput("rd_addr", {59'd0, rd_addr}, {59'd0, last_exp.rd});
        checkOutput("rd_data", {32'd0, rd_data}, {32'd0, last_exp.data});
        checkOutput("instret", instret, exp_instret);
    endtask

    initial begin
        logic [31:0] rnd;
        n_checks = 0; n_fail = 0;
        exp_instret = 64'd0; model_live = 1'b0;
        rst = 1'b0;
        mem_valid = 0; mem_reg_write = 0; mem_rd_addr = 0; mem_wb_sel = 0;
        mem_funct3 = 0; mem_alu_result = 0; mem_load_data = 0; mem_pc_plus4 = 0;
        stall = 0; flush = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_raw = 32'hA5A5_0001; rs2_raw = 32'h5A5A_0002;
        #1;
        checkOutput("rst_reg_write", {63'd0, reg_write}, 64'd0);
        checkOutput("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
        checkOutput("rst_rd_data", {32'd0, rd_data}, 64'd0);
        checkOutput("rst_instret", instret, 64'd0);
        checkOutput("rst_rs1_data", {32'd0, rs1_data}, 64'hA5A5_0001);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ALU write-back
        applyStimulus(1, 1, 5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
        // Load alignment vectors
        applyStimulus(1, 1, 5'd6, 2'd1, 3'b000, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
        applyStimulus(1, 1, 5'd6, 2'd1, 3'b100, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        applyStimulus(1, 1, 5'd6, 2'd1, 3'b001, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        applyStimulus(1, 1, 5'd6, 2'd1, 3'b101, 32'h0000_1000, 32'h80FF_7F01, 32'h0);
        checkOutput("lhu_const", {32'd0, rd_data}, 64'h0000_7F01);
        // PC+4 and reserved select
        applyStimulus(1, 1, 5'd1, 2'd2, 3'd0, 32'h0000_0ABC, 32'h0, 32'h0000_2004);
        applyStimulus(1, 1, 5'd2, 2'd3, 3'd0, 32'h0000_0ABC, 32'h0, 32'h0000_2004);
        // Random loads across all funct3 codes and offsets
        for (int i = 0; i < 10; i++) begin
            rnd = $urandom;
            applyStimulus(1, 1, 5'(i + 8), 2'd1, 3'($urandom_range(0, 7)),
                          rnd, $urandom, 32'h0);
        end

        // x0 destination: no write, still retires; x0 reads never bypass
        applyStimulus(1, 1, 5'd0, 2'd0, 3'd0, 32'h0000_7777, 32'h0, 32'h0);
        rs1_addr = 5'd0; rs1_raw = 32'h0BAD_F00D;
        #1 checkOutput("x0_rs1_data", {32'd0, rs1_data}, 64'h0BAD_F00D);

        // Same-cycle bypass to rs2, no match on rs1
        applyStimulus(1, 1, 5'd7, 2'd0, 3'd0, 32'h0000_DEAD, 32'h0, 32'h0);
        rs2_addr = 5'd7; rs2_raw = 32'h0000_1111;
        rs1_addr = 5'd8; rs1_raw = 32'h0000_2222;
        #1;
        checkOutput("bypass_rs2", {32'd0, rs2_data}, {32'd0, modelBypass(5'd7, 32'h1111, last_exp)});
        checkOutput("bypass_rs2_const", {32'd0, rs2_data}, 64'h0000_DEAD);
        checkOutput("bypass_rs1_miss", {32'd0, rs1_data}, {32'd0, modelBypass(5'd8, 32'h2222, last_exp)});
        // Non-writing instruction must not bypass
        applyStimulus(1, 0, 5'd7, 2'd0, 3'd0, 32'h0000_BEEF, 32'h0, 32'h0);
        #1 checkOutput("bypass_no_write", {32'd0, rs2_data}, 64'h0000_1111);

        // Stall three cycles on rd=3: single write, single retire
        applyStimulus(1, 1, 5'd3, 2'd0, 3'd0, 32'h0000_0033, 32'h0, 32'h0);
        stall = 1'b1; mem_valid = 1'b1; mem_rd_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            model_live = 1'b0;
            checkOutput("stall_reg_write", {63'd0, reg_write}, 64'd0);
            checkOutput("stall_rd_addr", {59'd0, rd_addr}, 64'd3);
            checkOutput("stall_instret", instret, exp_instret);
        end
        applyStimulus(1, 1, 5'd4, 2'd0, 3'd0, 32'h0000_0044, 32'h0, 32'h0);

        // Flush together with stall yields a bubble
        stall = 1'b1; flush = 1'b1; mem_valid = 1'b1; mem_rd_addr = 5'd6;
        tick();
        model_live = 1'b0;
        checkOutput("flush_reg_write", {63'd0, reg_write}, 64'd0);
        checkOutput("flush_instret", instret, exp_instret);
        applyStimulus(0, 1, 5'd6, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);

        // Reset in the middle of a stall drops the held entry
        applyStimulus(1, 1, 5'd10, 2'd0, 3'd0, 32'h0000_00AA, 32'h0, 32'h0);
        stall = 1'b1;
        rs1_addr = 5'd10; rs1_raw = 32'h0000_5555;
        #2 rst = 1'b0;
        #1;
        exp_instret = 64'd0; model_live = 1'b0;
        checkOutput("rst_mid_reg_write", {63'd0, reg_write}, 64'd0);
        checkOutput("rst_mid_instret", instret, 64'd0);
        checkOutput("rst_mid_rd_data", {32'd0, rd_data}, 64'd0);
        checkOutput("rst_mid_rs1_data", {32'd0, rs1_data}, 64'h0000_5555);
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        applyStimulus(1, 1, 5'd11, 2'd0, 3'd0, 32'h0000_0BBB, 32'h0, 32'h0);
        applyStimulus(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        checkOutput("sb_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
